// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter: round-robin arbiter and pacer for the shared CDC write port.
// One p_wr per grant, then a fixed gap before read-back and done.
module cdc_wr_arbiter #(
    parameter int AW  = 6,
    parameter int DW  = 16,
    parameter int GAP = 16
) (
    input  logic          clk_a,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] p_address,
    output logic [DW-1:0] p_data,
    output logic          p_wr,
    input  logic [DW-1:0] p_data_back
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(GAP - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       last_q;
    logic       win_q;
    logic       win_d;

    // On contention the requester not served last wins.
    always_comb begin
        win_d = (req0 && req1) ? ~last_q : req1;
    end

    assign busy = (state_q == WAIT);

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            p_wr      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            p_address <= '0;
            p_data    <= '0;
        end else begin
            p_wr  <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        p_address <= win_d ? addr1 : addr0;
                        p_data    <= win_d ? wdata1 : wdata0;
                        p_wr      <= 1'b1;
                        gnt0      <= ~win_d;
                        gnt1      <= win_d;
                        last_q    <= win_d;
                        win_q     <= win_d;
                        cnt_q     <= CNT_LOAD;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 8'd0) begin
                        rdata   <= p_data_back;
                        done0   <= ~win_q;
                        done1   <= win_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/cdc_wr_arbiter.md
# cdc_wr_arbiter

Two-requester write arbiter and pacer in the processor (clk_a) domain that shares the single CDC write port feeding the FIR configuration registers. It accepts write requests from the host bus path (requester 0) and the coefficient loader (requester 1), grants them round-robin, and issues exactly one single-cycle p_wr per transfer. It holds off further writes for a programmed gap covering the CDC round trip. At the end of that gap it samples p_data_back and returns the value to the winning requester with a done pulse.

## Interface
- AW, default 6: address width, matches CDC p_address.
- DW, default 16: data width, matches CDC p_data / p_data_back.
- GAP, default 16: cycles from p_wr assertion to done assertion; legal range 2..255; must cover the worst-case CDC req/ack round trip.
- clk_a  in  1  clock; this block uses only this clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req0  in  1  requester 0 write request, level; held until gnt0.
- addr0  in  AW  requester 0 address, valid while req0 is high.
- wdata0  in  DW  requester 0 write data, valid while req0 is high.
- gnt0  out  1  one-cycle pulse: requester 0 accepted, addr0/wdata0 captured.
- done0  out  1  one-cycle pulse: requester 0 transfer complete, rdata valid.
- req1, addr1, wdata1, gnt1, done1: same as above, for requester 1.
- rdata  out  DW  p_data_back sampled at completion; holds until the next completion.
- busy  out  1  high while a transfer is in flight (state WAIT).
- p_address  out  AW  to CDC.
- p_data  out  DW  to CDC.
- p_wr  out  1  to CDC; single-cycle write strobe.
- p_data_back  in  DW  from CDC.

## Operation
- All outputs are registered except busy, which decodes the state register.
- State machine:
  - IDLE: no transfer in flight.
  - WAIT: transfer in flight; down-counter cnt (8 bit) running.
- Round-robin pointer last: identifies the requester served most recently.
  - Reset value is 1, so requester 0 wins the first contention.
- IDLE with any req sampled high at a clk_a edge. At that edge:
  - Select the winner w: the only requester if one is high; if both are high, the requester != last.
  - p_address and p_data take addr_w and wdata_w.
  - p_wr <= 1; gnt_w <= 1; last <= w; cnt <= GAP-1; state <= WAIT.
- WAIT:
  - p_wr <= 0 and gnt_w <= 0 at the first edge.
  - cnt decrements at each edge.
  - At the edge where cnt == 0: rdata <= p_data_back; done_w <= 1; state <= IDLE.
- IDLE does not re-arbitrate on the same edge as the WAIT→IDLE transition. It arbitrates at the next edge, while done is high.
- p_address and p_data hold their values after p_wr falls, until the next grant.
- Requests raised during WAIT are not granted. They remain pending and are arbitrated in IDLE.
- A requester must drop req in the cycle after its gnt. If req is still high when IDLE is re-entered, it is a new request.
- The winner's identity is held in a register through WAIT, so done goes only to the granted requester.
- Reset values: p_wr, gnt0, gnt1, done0, done1, busy = 0; p_address = 0; p_data = 0; rdata = 0; state = IDLE; cnt = 0; last = 1.

## Timing
- req high at edge E in IDLE: p_wr, gnt_w and busy are high in cycle E..E+1.
- done_w is high in cycle E+GAP..E+GAP+1; busy is low from that cycle onward.
- p_wr is exactly one cycle wide.
- Minimum spacing between p_wr assertions is GAP+1 cycles (next grant at edge E+GAP+1).
- Throughput with both requesters saturated: alternating 0,1,0,1…, one transfer per GAP+1 cycles.
- Reset mid-WAIT: all outputs return to reset values asynchronously. The in-flight transfer is dropped with no done. After release, the first grant goes to requester 0 on contention.
- Both requests rising on the same edge as the WAIT→IDLE transition: neither is granted on that edge; winner decided at the next edge.

## Test plan
- GAP=16; req0=1, addr0=6'h05, wdata0=16'hA5A5 at edge 0; p_data_back=16'h1234 → p_wr/gnt0 high cycle 0..1; p_address=05, p_data=A5A5; done0 high cycle 16..17; rdata=1234; busy high cycles 0..15.
- After reset, req0 and req1 raised together → gnt0 first. While WAIT runs, req1 stays pending. gnt1 is high cycle 17..18, and the second p_wr comes exactly 17 cycles after the first.
- req0 and req1 held continuously, re-raised after each gnt, for 6 transfers → grants 0,1,0,1,0,1; no p_wr wider than 1 cycle; no two p_wr closer than GAP+1 cycles.
- req1 raised at cycle 5 of requester 0's WAIT → no gnt1 before done0; gnt1 on the edge after done0.
- rst_n pulsed low at cycle 8 of WAIT → all outputs 0 immediately, no done0. After release, req1 alone is granted normally with last updated to 1.
- GAP=2 with requester 0 saturated → p_wr every 3 cycles; done0 2 cycles after each p_wr; rdata tracks p_data_back at each completion.
